// File: rtl/fetch_decode_buffer.sv
// Two-entry FIFO skid buffer between fetch and decode; registered head, flush discards contents.
// Latency: a word accepted at edge N is presented to decode in the cycle after edge N (no bypass).
// Backpressure: fetch_o_ready drops only when both entries are full; it comes from registered count only.
module fetch_decode_buffer #(
  parameter int BUS_W    = 96,
  parameter int COMMIT_W = 161
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_i_valid,
  output logic                fetch_o_ready,
  input  logic [BUS_W-1:0]    fetch_i_bus_info,
  input  logic [COMMIT_W-1:0] fetch_i_commit_info,
  input  logic                flush_i,
  output logic                decode_o_valid,
  input  logic                decode_i_ready,
  output logic [BUS_W-1:0]    decode_o_bus_info,
  output logic [COMMIT_W-1:0] decode_o_commit_info,
  output logic [31:0]         stall_cnt_o
);

  logic [BUS_W-1:0]    bus_q    [2];
  logic [COMMIT_W-1:0] commit_q [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;
  logic                push;
  logic                pop;

  // Ready/valid come straight from the occupancy register, so neither side sees a
  // combinational path from the other; a pop while full frees space only next cycle.
  assign fetch_o_ready  = (count != 2'd2);
  assign decode_o_valid = (count != 2'd0);

  assign push = fetch_i_valid & fetch_o_ready & ~flush_i;
  assign pop  = decode_o_valid & decode_i_ready & ~flush_i;

  // Head entry is driven from storage only; zeros mark a bubble when empty.
  assign decode_o_bus_info    = decode_o_valid ? bus_q[rd_ptr]    : '0;
  assign decode_o_commit_info = decode_o_valid ? commit_q[rd_ptr] : '0;

  // Storage, pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bus_q[i]    <= '0;
        commit_q[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        bus_q[wr_ptr]    <= fetch_i_bus_info;
        commit_q[wr_ptr] <= fetch_i_commit_info;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Performance counter: cycles where decode holds off a valid head; survives flush, wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
    end else if (decode_o_valid && !decode_i_ready && !flush_i) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: expected words queued on accept, compared at the head.
module tb_fetch_decode_buffer;

  localparam int BUS_W    = 96;
  localparam int COMMIT_W = 161;
  localparam int WORD_W   = BUS_W + COMMIT_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                fetch_i_valid;
  logic                fetch_o_ready;
  logic [BUS_W-1:0]    fetch_i_bus_info;
  logic [COMMIT_W-1:0] fetch_i_commit_info;
  logic                flush_i;
  logic                decode_o_valid;
  logic                decode_i_ready;
  logic [BUS_W-1:0]    decode_o_bus_info;
  logic [COMMIT_W-1:0] decode_o_commit_info;
  logic [31:0]         stall_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WORD_W-1:0] sb[$];
  logic [31:0]       exp_stall;

  fetch_decode_buffer #(.BUS_W(BUS_W), .COMMIT_W(COMMIT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .fetch_i_valid        (fetch_i_valid),
    .fetch_o_ready        (fetch_o_ready),
    .fetch_i_bus_info     (fetch_i_bus_info),
    .fetch_i_commit_info  (fetch_i_commit_info),
    .flush_i              (flush_i),
    .decode_o_valid       (decode_o_valid),
    .decode_i_ready       (decode_i_ready),
    .decode_o_bus_info    (decode_o_bus_info),
    .decode_o_commit_info (decode_o_commit_info),
    .stall_cnt_o          (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return 32'h0000_0513 | {pc[11:0], 20'h0};
  endfunction

  function automatic logic [COMMIT_W-1:0] commit_of(input logic [63:0] pc);
    return {1'b1, instr_of(pc), pc + 64'd4, pc};
  endfunction

  task automatic drive_word(input logic [63:0] pc);
    fetch_i_valid       = 1'b1;
    fetch_i_bus_info    = {pc, instr_of(pc)};
    fetch_i_commit_info = commit_of(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates at the falling edge using the inputs that the next rising edge will see.
  always @(negedge clk) begin
    int  sz;
    logic do_push;
    logic do_pop;
    if (rst) begin
      sb.delete();
      exp_stall = 32'd0;
    end else begin
      sz = sb.size();
      check_eq("fetch_ready", {259'd0, fetch_o_ready}, {259'd0, (sz != 2)});
      check_eq("decode_valid", {259'd0, decode_o_valid}, {259'd0, (sz != 0)});
      check_eq("stall_cnt", {228'd0, stall_cnt_o}, {228'd0, exp_stall});
      if (sz != 0)
        check_eq("head_word", {3'd0, decode_o_bus_info, decode_o_commit_info}, {3'd0, sb[0]});
      else
        check_eq("empty_zero", {3'd0, decode_o_bus_info, decode_o_commit_info}, 260'd0);
      if (flush_i) begin
        sb.delete();
      end else begin
        do_pop  = decode_i_ready && (sz != 0);
        do_push = fetch_i_valid && (sz != 2);
        if (sz != 0 && !decode_i_ready) exp_stall = exp_stall + 32'd1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back({fetch_i_bus_info, fetch_i_commit_info});
      end
    end
  end

  initial begin
    rst                 = 1'b1;
    fetch_i_valid       = 1'b0;
    fetch_i_bus_info    = '0;
    fetch_i_commit_info = '0;
    flush_i             = 1'b0;
    decode_i_ready      = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_ready", {259'd0, fetch_o_ready}, 260'd1);
    check_eq("rst_valid", {259'd0, decode_o_valid}, 260'd0);
    check_eq("rst_stall", {228'd0, stall_cnt_o}, 260'd0);

    // Single push, consumed immediately
    drive_word(64'h8000_0000);
    decode_i_ready = 1'b1;
    step();
    fetch_i_valid = 1'b0;
    @(negedge clk);
    check_eq("single_valid", {259'd0, decode_o_valid}, 260'd1);
    check_eq("single_bus", {164'd0, decode_o_bus_info}, {164'd0, 64'h8000_0000, 32'h0000_0513});
    check_eq("single_commit", {99'd0, decode_o_commit_info},
             {99'd0, 1'b1, 32'h0000_0513, 64'h8000_0004, 64'h8000_0000});
    step();
    @(negedge clk);
    check_eq("single_drained", {259'd0, decode_o_valid}, 260'd0);
    check_eq("single_commit0", {99'd0, decode_o_commit_info}, 260'd0);

    // Back-pressure fill; third word refused
    decode_i_ready = 1'b0;
    drive_word(64'h8000_0000);
    step();
    drive_word(64'h8000_0004);
    step();
    drive_word(64'h8000_0008);
    @(negedge clk);
    check_eq("full_ready", {259'd0, fetch_o_ready}, 260'd0);
    step();
    @(negedge clk);
    check_eq("full_stall2", {228'd0, stall_cnt_o}, 260'd2);
    check_eq("full_still", {259'd0, fetch_o_ready}, 260'd0);

    // Drain in order; ready recovers one cycle after first pop
    fetch_i_valid  = 1'b0;
    decode_i_ready = 1'b1;
    step();
    @(negedge clk);
    check_eq("drain_ready", {259'd0, fetch_o_ready}, 260'd1);
    check_eq("drain_pc2", {196'd0, decode_o_bus_info[95:32]}, 260'h8000_0004);
    step();
    @(negedge clk);
    check_eq("drain_empty", {259'd0, decode_o_valid}, 260'd0);

    // Streaming at occupancy 1
    drive_word(64'h8000_0000);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive_word(64'h8000_0000 + 64'(i * 4));
      @(negedge clk);
      check_eq("stream_valid", {259'd0, decode_o_valid}, 260'd1);
      check_eq("stream_ready", {259'd0, fetch_o_ready}, 260'd1);
      check_eq("stream_pc", {196'd0, decode_o_bus_info[95:32]}, {196'd0, 64'h8000_0000 + 64'((i - 1) * 4)});
      step();
    end
    fetch_i_valid = 1'b0;
    step();
    step();

    // Flush while full, with simultaneous push and pop
    decode_i_ready = 1'b0;
    drive_word(64'h8000_0100);
    step();
    drive_word(64'h8000_0104);
    step();
    drive_word(64'h8000_0108);
    decode_i_ready = 1'b1;
    flush_i        = 1'b1;
    step();
    flush_i       = 1'b0;
    fetch_i_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", {259'd0, decode_o_valid}, 260'd0);
    check_eq("flush_bit160", {259'd0, decode_o_commit_info[160]}, 260'd0);
    drive_word(64'h8000_1000);
    step();
    fetch_i_valid = 1'b0;
    @(negedge clk);
    check_eq("post_flush_pc", {196'd0, decode_o_bus_info[95:32]}, 260'h8000_1000);
    step();
    step();

    // Reset mid-operation: full, stall count 5
    rst = 1'b1;
    step();
    rst = 1'b0;
    decode_i_ready = 1'b0;
    drive_word(64'h8000_2000);
    step();
    drive_word(64'h8000_2004);
    step();
    fetch_i_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check_eq("pre_rst_stall5", {228'd0, stall_cnt_o}, 260'd5);
    check_eq("pre_rst_full", {259'd0, fetch_o_ready}, 260'd0);
    rst            = 1'b1;
    decode_i_ready = 1'b1;
    drive_word(64'h8000_3000);
    step();
    rst           = 1'b0;
    fetch_i_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_stall", {228'd0, stall_cnt_o}, 260'd0);
    check_eq("mid_rst_ready", {259'd0, fetch_o_ready}, 260'd1);
    check_eq("mid_rst_valid", {259'd0, decode_o_valid}, 260'd0);
    check_eq("mid_rst_data", {3'd0, decode_o_bus_info, decode_o_commit_info}, 260'd0);
    step();
    @(negedge clk);
    check_eq("sb_empty_end", 260'(sb.size()), 260'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
